// File: rtl/pps_divider_if.sv
`timescale 1ns/1ps
// Register-bank to timing-core bundle for the PPS divider.
// Configuration words flow to the core and pulse status flows back.
interface pps_divider_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] periodic_true;
  logic [DATA_WIDTH-1:0] div_number;
  logic [31:0]           phase_us;
  logic [DATA_WIDTH-1:0] width_us;
  logic [DATA_WIDTH-1:0] start;
  logic [DATA_WIDTH-1:0] stop;
  logic                  pulse;
  logic                  busy;
  logic [DATA_WIDTH-1:0] event_idx;
  logic                  missed;

  modport master (
    output periodic_true, div_number, phase_us, width_us, start, stop,
    input  pulse, busy, event_idx, missed
  );

  modport slave (
    input  periodic_true, div_number, phase_us, width_us, start, stop,
    output pulse, busy, event_idx, missed
  );
endinterface

// File: rtl/pps_divider.sv
`timescale 1ns/1ps
// PPS divider: emits one phased, fixed-width pulse for every Nth GPS PPS edge,
// either continuously or for a window of trigger indices.
module pps_divider #(
  parameter int DATA_WIDTH = 8,
  parameter int CYC_PER_US = 10
) (
  input  logic          i_clk_10,
  input  logic          i_rst,
  input  logic          i_pps,
  pps_divider_if.slave  bus
);

  localparam int PW = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
  localparam logic [PW-1:0]         PRESC_LAST = PW'(CYC_PER_US - 1);
  localparam logic [DATA_WIDTH-1:0] IDX_MAX    = '1;
  localparam logic [DATA_WIDTH-1:0] ONE        = DATA_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    HIGH
  } state_t;

  state_t                state, state_nx;
  logic [2:0]            pps_sh;
  logic                  pps_edge;
  logic                  trigger;
  logic                  enabled;
  logic                  us_tick;
  logic [DATA_WIDTH-1:0] div_last;
  logic [DATA_WIDTH-1:0] div_cnt, div_cnt_nx;
  logic [DATA_WIDTH-1:0] trig_cnt, trig_cnt_nx;
  logic [DATA_WIDTH-1:0] event_idx_q, event_idx_nx;
  logic                  missed_q, missed_nx;
  logic [PW-1:0]         presc, presc_nx;
  logic [31:0]           delay_cnt, delay_cnt_nx;
  logic [DATA_WIDTH-1:0] width_cnt, width_cnt_nx;
  logic                  pulse_q, busy_q;

  // pps_sh[0..1] synchronise the asynchronous PPS, pps_sh[2] is the history bit.
  assign pps_edge = pps_sh[1] & ~pps_sh[2];
  assign trigger  = pps_edge && (div_cnt == '0);
  assign div_last = (bus.div_number == '0) ? '0 : bus.div_number - ONE;
  assign enabled  = (bus.periodic_true != '0) ||
                    ((trig_cnt >= bus.start) && (trig_cnt <= bus.stop));
  assign us_tick  = (presc == PRESC_LAST);

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx     = state;
    div_cnt_nx   = div_cnt;
    trig_cnt_nx  = trig_cnt;
    event_idx_nx = event_idx_q;
    missed_nx    = missed_q;
    presc_nx     = us_tick ? '0 : presc + PW'(1);
    delay_cnt_nx = delay_cnt;
    width_cnt_nx = width_cnt;

    if (pps_edge) begin
      div_cnt_nx = (div_cnt >= div_last) ? '0 : div_cnt + ONE;
    end

    if (trigger) begin
      event_idx_nx = trig_cnt;
      if (trig_cnt != IDX_MAX) begin
        trig_cnt_nx = trig_cnt + ONE;
      end
      if (state != IDLE) begin
        missed_nx = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (trigger && enabled && (bus.width_us != '0)) begin
          presc_nx     = '0;
          delay_cnt_nx = bus.phase_us;
          width_cnt_nx = bus.width_us;
          // Zero phase skips DELAY so the pulse rises on the trigger edge itself.
          state_nx     = (bus.phase_us == 32'd0) ? HIGH : DELAY;
        end
      end
      DELAY: begin
        if (us_tick) begin
          if (delay_cnt <= 32'd1) begin
            presc_nx = '0;
            state_nx = HIGH;
          end else begin
            delay_cnt_nx = delay_cnt - 32'd1;
          end
        end
      end
      HIGH: begin
        if (us_tick) begin
          if (width_cnt <= ONE) begin
            state_nx = IDLE;
          end else begin
            width_cnt_nx = width_cnt - ONE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk_10) begin
    if (i_rst) begin
      state       <= IDLE;
      pps_sh      <= '0;
      div_cnt     <= '0;
      trig_cnt    <= '0;
      event_idx_q <= '0;
      missed_q    <= 1'b0;
      presc       <= '0;
      delay_cnt   <= '0;
      width_cnt   <= '0;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nx;
      pps_sh      <= {pps_sh[1:0], i_pps};
      div_cnt     <= div_cnt_nx;
      trig_cnt    <= trig_cnt_nx;
      event_idx_q <= event_idx_nx;
      missed_q    <= missed_nx;
      presc       <= presc_nx;
      delay_cnt   <= delay_cnt_nx;
      width_cnt   <= width_cnt_nx;
      pulse_q     <= (state_nx == HIGH);
      busy_q      <= (state_nx != IDLE);
    end
  end

  assign bus.pulse     = pulse_q;
  assign bus.busy      = busy_q;
  assign bus.event_idx = event_idx_q;
  assign bus.missed    = missed_q;

endmodule

// File: tb/tb_pps_divider.sv
`timescale 1ns/1ps
// Randomised bench for pps_divider: a PPS-level model predicts every pulse
// and status value; a monitor matches observed pulses against the queue.
module tb_pps_divider;

  localparam int CYC = 10;

  typedef struct {
    int rise;
    int width;
  } exp_t;

  logic i_clk_10 = 1'b0;
  logic i_rst    = 1'b1;
  logic i_pps    = 1'b0;

  pps_divider_if #(.DATA_WIDTH(8)) bus ();

  pps_divider #(.DATA_WIDTH(8), .CYC_PER_US(CYC)) dut (
    .i_clk_10 (i_clk_10),
    .i_rst    (i_rst),
    .i_pps    (i_pps),
    .bus      (bus)
  );

  always #50 i_clk_10 = ~i_clk_10;

  int   cyc = 0;
  always @(posedge i_clk_10) cyc <= cyc + 1;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  int   pps_count, trig_count, model_idx, model_missed, last_fall;
  bit   in_pulse   = 1'b0;
  bit   busy_seen  = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit enabled(input int idx);
    return (bus.periodic_true != 0) || ((idx >= int'(bus.start)) && (idx <= int'(bus.stop)));
  endfunction

  // Monitor: each finished pulse is matched against the oldest expected one.
  initial begin : monitor
    bit   rst_seen;
    int   rise_c;
    exp_t e;
    forever begin
      @(posedge i_clk_10);
      rst_seen = i_rst;
      @(negedge i_clk_10);
      if (bus.busy) busy_seen = 1'b1;
      if (rst_seen) begin
        in_pulse = 1'b0;
      end else if (bus.pulse && !in_pulse) begin
        in_pulse = 1'b1;
        rise_c   = cyc;
      end else if (!bus.pulse && in_pulse) begin
        in_pulse = 1'b0;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pulse: rose at cycle %0d width %0d, none expected", rise_c, cyc - rise_c);
        end else begin
          e = exp_q.pop_front();
          check("pulse_rise", rise_c, e.rise);
          check("pulse_width", cyc - rise_c, e.width);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge i_clk_10);
    i_rst = 1'b1;
    @(negedge i_clk_10);
    check("rst_pulse", bus.pulse, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_event_idx", bus.event_idx, 0);
    check("rst_missed", bus.missed, 0);
    i_rst        = 1'b0;
    pps_count    = 0;
    trig_count   = 0;
    model_idx    = 0;
    model_missed = 0;
    last_fall    = -1;
    exp_q.delete();
    busy_seen    = 1'b0;
  endtask

  task automatic set_cfg(input int periodic, input int n, input int phase,
                         input int width, input int st, input int sp);
    bus.periodic_true = 8'(periodic);
    bus.div_number    = 8'(n);
    bus.phase_us      = 32'(phase);
    bus.width_us      = 8'(width);
    bus.start         = 8'(st);
    bus.stop          = 8'(sp);
  endtask

  // One PPS rising edge, held high for hi cycles, then low for gap cycles.
  // The trigger takes effect on the third clock edge that sees PPS high.
  task automatic apply_pps(input int hi, input int gap);
    int n_eff, t, rise, fall;
    t     = cyc + 3;
    n_eff = (bus.div_number == 0) ? 1 : int'(bus.div_number);
    if ((pps_count % n_eff) == 0) begin
      model_idx = trig_count;
      if (trig_count < 255) trig_count++;
      if (t <= last_fall) begin
        model_missed = 1;
      end else if (enabled(model_idx) && bus.width_us != 0) begin
        rise = t + CYC * int'(bus.phase_us);
        fall = rise + CYC * int'(bus.width_us);
        exp_q.push_back('{rise, fall - rise});
        last_fall = fall;
      end
    end
    pps_count++;
    i_pps = 1'b1;
    for (int k = 1; k <= hi + gap; k++) begin
      @(negedge i_clk_10);
      if (k == hi) i_pps = 1'b0;
      if (cyc == t) begin
        check("event_idx", bus.event_idx, model_idx);
        check("missed", bus.missed, model_missed);
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || in_pulse || cyc <= last_fall) && n < budget) begin
      @(negedge i_clk_10);
      n++;
    end
    check("drain_pending_pulses", exp_q.size(), 0);
    check("drain_pulse_stuck", in_pulse, 0);
    repeat (2) @(negedge i_clk_10);
    check("drain_busy", bus.busy, 0);
    check("drain_event_idx", bus.event_idx, model_idx);
    check("drain_missed", bus.missed, model_missed);
  endtask

  initial begin : stimulus
    int n_pps, waited;
    set_cfg(1, 1, 0, 5, 0, 0);
    repeat (2) @(negedge i_clk_10);
    do_reset();

    // Every PPS triggers, zero phase, 50-cycle pulses.
    set_cfg(1, 1, 0, 5, 0, 0);
    for (int i = 0; i < 3; i++) apply_pps($urandom_range(1, 20), 200);
    drain(3000);

    // Divide by 3 with a 100 us phase.
    do_reset();
    set_cfg(1, 3, 100, 2, 0, 0);
    for (int i = 0; i < 7; i++) apply_pps($urandom_range(1, 20), 1100);
    drain(3000);

    // Window of trigger indices 2..3.
    do_reset();
    set_cfg(0, 1, 3, 3, 2, 3);
    for (int i = 0; i < 6; i++) apply_pps($urandom_range(1, 20), 100);
    drain(3000);

    // Zero width never pulses and never goes busy.
    do_reset();
    set_cfg(1, 1, 2, 0, 0, 0);
    for (int i = 0; i < 3; i++) apply_pps(3, 60);
    drain(3000);
    check("width0_busy_seen", busy_seen, 0);

    // Empty window (start > stop).
    do_reset();
    set_cfg(0, 1, 1, 4, 5, 2);
    for (int i = 0; i < 8; i++) apply_pps(2, 40);
    drain(3000);
    check("empty_window_busy_seen", busy_seen, 0);

    // Phase longer than the PPS period: second trigger dropped; config writes
    // during DELAY leave the running pulse untouched.
    do_reset();
    set_cfg(1, 1, 40, 3, 0, 0);
    apply_pps(5, 100);
    bus.phase_us = 32'd5;
    bus.width_us = 8'd7;
    apply_pps(5, 395);
    apply_pps(5, 100);
    drain(3000);

    // Trigger index saturates at 255.
    do_reset();
    set_cfg(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 258; i++) apply_pps(1, 4);
    drain(3000);

    // Reset while the pulse is high, then the next PPS is index 0 again.
    do_reset();
    set_cfg(1, 1, 0, 8, 0, 0);
    apply_pps(2, 4);
    waited = 0;
    while (!bus.pulse && waited < 50) begin
      @(negedge i_clk_10);
      waited++;
    end
    check("midpulse_pulse_high", bus.pulse, 1);
    do_reset();
    apply_pps(2, 10);
    drain(3000);

    // Randomised configurations.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      set_cfg($urandom_range(0, 1), $urandom_range(0, 4), $urandom_range(0, 30),
              $urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 7));
      n_pps = $urandom_range(4, 8);
      for (int i = 0; i < n_pps; i++) apply_pps($urandom_range(1, 20), $urandom_range(4, 400));
      drain(3000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pps_divider.md
Name: pps_divider

Overview:
- Timing core driven by the pps divider register bank. Consumes the periodic flag, division number, 32-bit phase, width, start and stop configuration words, plus the raw GPS PPS input.
- Generates one output pulse for every Nth PPS edge. Each pulse is delayed by a programmable number of microseconds and lasts a programmable number of microseconds.
- Runs either continuously or only for a window of trigger indices.
- Sits between the register bank and the clock-output mux, in the i_clk_10 (10 MHz) domain.

Parameters:
- DATA_WIDTH, 8, width of the configuration words.
- CYC_PER_US, 10, i_clk_10 cycles per microsecond.

Ports:
- i_clk_10  in  1  10 MHz system clock.
- i_rst  in  1  Synchronous active-high reset.
- i_pps  in  1  Raw PPS from GPS receiver, asynchronous to i_clk_10.
- i_periodic_true  in  8  Nonzero = periodic mode; zero = windowed mode.
- i_div_number  in  8  PPS division factor N; 0 is treated as 1.
- i_phase_us  in  32  Delay from trigger to pulse rise, in microseconds.
- i_width_us  in  8  Pulse width in microseconds; 0 = no pulse.
- i_start  in  8  First enabled trigger index (windowed mode).
- i_stop  in  8  Last enabled trigger index (windowed mode), inclusive.
- o_pulse  out  1  Divided, phased pulse output.
- o_busy  out  1  High while in DELAY or HIGH.
- o_event_idx  out  8  Trigger index of the most recent trigger; saturates at 255.
- o_missed  out  1  Sticky flag: a trigger arrived while busy.

Behaviour:
- Reset is synchronous, active-high: reset i_rst, clock i_clk_10. Reset values:
  - o_pulse=0, o_busy=0, o_event_idx=0, o_missed=0.
  - Synchronizer flops = 0, PPS division counter = 0, trigger count = 0, state = IDLE.
- PPS synchronization: i_pps passes through 2 synchronizer flops and a third history flop. edge = s2 & ~s3. There is exactly one edge per PPS rising edge, regardless of PPS high time.
- Division counter div_cnt (8 bit), updated on each edge:
  - A trigger fires when div_cnt==0. The first PPS after reset is therefore a trigger.
  - div_cnt then increments; when it reaches max(N,1)-1 it wraps to 0.
  - i_div_number is read live. If it is changed so that div_cnt >= new N-1, the next edge wraps div_cnt to 0.
- Trigger index:
  - Every trigger, accepted or dropped, captures trig_cnt into o_event_idx, then increments trig_cnt (saturating at 255).
  - The first trigger has index 0.
- Enable condition for a trigger:
  - Periodic mode: (i_periodic_true != 0) — every trigger is enabled.
  - Windowed mode: enabled when i_start <= idx <= i_stop. If i_start > i_stop, no trigger is ever enabled.
- Configuration latching: on an enabled trigger in IDLE, i_phase_us and i_width_us are latched. Later register writes do not affect a pulse in progress.
- Microsecond timing: a prescaler counts 0..CYC_PER_US-1 and is reset to 0 on entry to DELAY and on entry to HIGH. One microsecond = 10 cycles.
- State machine:
  - IDLE -> DELAY on an enabled trigger with width != 0. The delay counter loads the latched phase.
  - Enabled trigger with width == 0: stay in IDLE, no pulse.
  - DELAY: the delay counter decrements once per microsecond. When it is 0, go to HIGH. Phase 0 means HIGH is entered on the cycle after the trigger.
  - HIGH: o_pulse=1 (registered). The width counter counts down the latched width. After exactly width*10 cycles, o_pulse=0 and the state returns to IDLE.
  - o_busy=1 in DELAY and HIGH.
- Latency: o_pulse rises exactly 3 + 10*phase i_clk_10 rising edges after the edge that first samples i_pps high, counting that sampling edge as edge 1.
- Trigger while busy: the trigger is dropped, o_missed is set, and div_cnt and trig_cnt still advance. The pulse in progress is not retriggered or extended.
- o_missed clears only on i_rst.
- Phase arithmetic: 32-bit unsigned, no overflow handling. Phases of 1 s or more cause missed triggers.
- Reset mid-pulse: o_pulse drops on the next clock edge and all state returns to its reset values.

Test Plan:
- N=1, periodic=1, phase=0, width=5; PPS pulses 1 s apart -> o_pulse high for 50 cycles, rising 3 cycles after each PPS is sampled. o_event_idx = 0, 1, 2.
- N=3, phase=100, width=2; 7 PPS edges -> pulses only after PPS #1, #4, #7. Each rises 1003 cycles after its PPS and is 20 cycles wide.
- Windowed mode, start=2, stop=3, N=1; 6 PPS edges -> pulses only for indices 2 and 3. o_event_idx ends at 5.
- Width=0 -> no pulse and o_busy stays 0. Start=5, stop=2 -> no pulse ever.
- phase=1500000 with PPS every 1 s -> the second trigger is dropped, o_missed=1, and the first pulse completes with unchanged timing. A phase register write during DELAY does not alter the pulse.
- Assert i_rst while o_pulse=1 -> o_pulse=0, o_missed=0, o_event_idx=0 next cycle. The next PPS is treated as trigger index 0.
